lz77_min_match_filter: RTL and testbench



---
 rtl/lz77_min_match_filter.sv | 217 +++++++++++++++++++++
 tb/tb_lz77_min_match_filter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_min_match_filter.sv
// -----------------------------------------------------------------------------
// lz77_min_match_filter
//
// Sits between the LZ77 match engine and the token encoder. Match tokens
// shorter than MIN_MATCH are rewritten as a run of literal tokens. The run is
// rebuilt from a small history ring that holds the raw symbols the match
// covered. Literal tokens and matches of length >= MIN_MATCH pass through
// unchanged.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both 1. A producer holds valid and its payload stable
// until that transfer. The output register holds all fields stable while
// output_valid & ~output_ready.
//
// Ports
//   clk                      clock, all logic on the rising edge
//   rst_n                    synchronous active-low reset
//   input_valid/ready        input beat handshake
//   input_symbol             raw symbol (next_symbol when input_token_end=1)
//   input_token_end          beat closes a token
//   input_match_position     token position (end beats only)
//   input_match_length       token length, 0 = literal (end beats only)
//   input_last_symbol        final beat of the stream
//   output_valid/ready       output token handshake
//   output_match_position    token position
//   output_match_length      token length
//   output_match_next_symbol token symbol
//   output_match_valid       1 = match token, 0 = literal
//   output_last_symbol       final token of the stream
//   output_error             sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module lz77_min_match_filter #(
   parameter int DATA_WIDTH           = 8,
   parameter int DICTIONARY_DEPTH_LOG = 16,
   parameter int CNT_WIDTH            = 9,
   parameter int MIN_MATCH            = 3,
   parameter int LITERAL_POSITION     = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            input_valid,
   output logic                            input_ready,
   input  logic [DATA_WIDTH-1:0]           input_symbol,
   input  logic                            input_token_end,
   input  logic [DICTIONARY_DEPTH_LOG:0]   input_match_position,
   input  logic [CNT_WIDTH-1:0]            input_match_length,
   input  logic                            input_last_symbol,
   output logic                            output_valid,
   input  logic                            output_ready,
   output logic [DICTIONARY_DEPTH_LOG:0]   output_match_position,
   output logic [CNT_WIDTH-1:0]            output_match_length,
   output logic [DATA_WIDTH-1:0]           output_match_next_symbol,
   output logic                            output_match_valid,
   output logic                            output_last_symbol,
   output logic                            output_error
);

   localparam int HDEPTH = MIN_MATCH - 1;
   // Pointer width; a depth-1 ring still gets a 1-bit pointer that stays 0.
   localparam int PW     = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;
   localparam int POS_W  = DICTIONARY_DEPTH_LOG + 1;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] MIN_LEN  = CNT_WIDTH'(MIN_MATCH);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [PW:0]          HDEPTH_X = (PW+1)'(HDEPTH);
   localparam logic [PW-1:0]        PTR_LAST = PW'(HDEPTH - 1);
   localparam logic [POS_W-1:0]     LIT_POS  = POS_W'(LITERAL_POSITION);

   typedef enum logic [0:0] {
      ST_PASS   = 1'b0,
      ST_EXPAND = 1'b1
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] ring [HDEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [CNT_WIDTH-1:0]  pending_cnt;
   logic [CNT_WIDTH-1:0]  idx;
   logic [CNT_WIDTH-1:0]  exp_len;
   logic [DATA_WIDTH-1:0] held_sym;
   logic                  held_last;

   logic                  slot_free;
   logic                  accept;
   logic                  data_beat;
   logic                  end_beat;
   logic                  short_match;
   logic                  len_bad;
   logic                  proto_err;
   logic [PW:0]           rd_start_x;
   logic [PW-1:0]         rd_start;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // The output slot can take a new token when it is empty or being drained.
   assign slot_free   = ~output_valid | output_ready;
   assign input_ready = rst_n & (state == ST_PASS) & slot_free;
   assign accept      = input_valid & input_ready;
   assign data_beat   = accept & ~input_token_end;
   assign end_beat    = accept & input_token_end;

   assign short_match = (input_match_length != '0) && (input_match_length < MIN_LEN);

   // A saturated pending count no longer tracks the true symbol count, so the
   // length check is skipped in that case.
   assign len_bad   = (input_match_length != pending_cnt) && (pending_cnt != CNT_MAX);
   assign proto_err = (end_beat & len_bad) | (accept & input_last_symbol & ~input_token_end);

   // Oldest covered symbol sits L entries behind wptr. End beats never write
   // the ring, so wptr is still the post-data-beat value here. L <= HDEPTH
   // whenever this is used, so one conditional subtract finishes the modulo.
   always_comb begin
      rd_start_x = {1'b0, wptr} + HDEPTH_X - input_match_length[PW:0];
      if (rd_start_x >= HDEPTH_X) begin
         rd_start_x = rd_start_x - HDEPTH_X;
      end
      rd_start = rd_start_x[PW-1:0];
   end

   // History storage; no reset needed because it is only read after writes.
   always_ff @(posedge clk) begin
      if (data_beat) begin
         ring[wptr] <= input_symbol;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                    <= ST_PASS;
         wptr                     <= '0;
         rptr                     <= '0;
         pending_cnt              <= '0;
         idx                      <= '0;
         exp_len                  <= '0;
         held_sym                 <= '0;
         held_last                <= 1'b0;
         output_valid             <= 1'b0;
         output_match_position    <= '0;
         output_match_length      <= '0;
         output_match_next_symbol <= '0;
         output_match_valid       <= 1'b0;
         output_last_symbol       <= 1'b0;
         output_error             <= 1'b0;
      end else begin
         if (data_beat) begin
            wptr <= ptr_inc(wptr);
            if (pending_cnt != CNT_MAX) begin
               pending_cnt <= pending_cnt + CNT_ONE;
            end
         end
         if (end_beat) begin
            pending_cnt <= '0;
         end
         if (proto_err) begin
            output_error <= 1'b1;
         end

         case (state)
            ST_PASS: begin
               if (end_beat) begin
                  output_valid <= 1'b1;
                  if (short_match) begin
                     // Literal 0 goes out now; the rest follow from EXPAND.
                     output_match_position    <= LIT_POS;
                     output_match_length      <= '0;
                     output_match_next_symbol <= ring[rd_start];
                     output_match_valid       <= 1'b0;
                     output_last_symbol       <= 1'b0;
                     rptr                     <= ptr_inc(rd_start);
                     idx                      <= CNT_ONE;
                     exp_len                  <= input_match_length;
                     held_sym                 <= input_symbol;
                     held_last                <= input_last_symbol;
                     state                    <= ST_EXPAND;
                  end else begin
                     output_match_position    <= input_match_position;
                     output_match_length      <= input_match_length;
                     output_match_next_symbol <= input_symbol;
                     output_match_valid       <= (input_match_length != '0);
                     output_last_symbol       <= input_last_symbol;
                  end
               end else if (output_ready) begin
                  output_valid <= 1'b0;
               end
            end

            ST_EXPAND: begin
               if (slot_free) begin
                  output_valid          <= 1'b1;
                  output_match_position <= LIT_POS;
                  output_match_length   <= '0;
                  output_match_valid    <= 1'b0;
                  if (idx == exp_len) begin
                     // Final literal of the group is the held next_symbol.
                     output_match_next_symbol <= held_sym;
                     output_last_symbol       <= held_last;
                     idx                      <= '0;
                     state                    <= ST_PASS;
                  end else begin
                     output_match_next_symbol <= ring[rptr];
                     output_last_symbol       <= 1'b0;
                     rptr                     <= ptr_inc(rptr);
                     idx                      <= idx + CNT_ONE;
                  end
               end
            end

            default: state <= ST_PASS;
         endcase
      end
   end

endmodule

// File: tb/tb_lz77_min_match_filter.sv
// -----------------------------------------------------------------------------
// Directed bench for lz77_min_match_filter. Instance a uses default
// parameters, instance b uses MIN_MATCH=5 for the ring-wrap case.
// -----------------------------------------------------------------------------
module tb_lz77_min_match_filter;

   logic clk;
   int   vectors;
   int   miscompares;

   // ---------------- instance a (defaults) ----------------
   logic        a_rst_n, a_input_valid, a_input_ready, a_input_token_end, a_input_last_symbol;
   logic [7:0]  a_input_symbol;
   logic [16:0] a_input_match_position;
   logic [8:0]  a_input_match_length;
   logic        a_output_valid, a_output_ready, a_output_match_valid, a_output_last_symbol, a_output_error;
   logic [16:0] a_output_match_position;
   logic [8:0]  a_output_match_length;
   logic [7:0]  a_output_match_next_symbol;

   lz77_min_match_filter dut_a (
      .clk                      (clk),
      .rst_n                    (a_rst_n),
      .input_valid              (a_input_valid),
      .input_ready              (a_input_ready),
      .input_symbol             (a_input_symbol),
      .input_token_end          (a_input_token_end),
      .input_match_position     (a_input_match_position),
      .input_match_length       (a_input_match_length),
      .input_last_symbol        (a_input_last_symbol),
      .output_valid             (a_output_valid),
      .output_ready             (a_output_ready),
      .output_match_position    (a_output_match_position),
      .output_match_length      (a_output_match_length),
      .output_match_next_symbol (a_output_match_next_symbol),
      .output_match_valid       (a_output_match_valid),
      .output_last_symbol       (a_output_last_symbol),
      .output_error             (a_output_error)
   );

   // ---------------- instance b (MIN_MATCH=5) ----------------
   logic        b_rst_n, b_input_valid, b_input_ready, b_input_token_end, b_input_last_symbol;
   logic [7:0]  b_input_symbol;
   logic [16:0] b_input_match_position;
   logic [8:0]  b_input_match_length;
   logic        b_output_valid, b_output_ready, b_output_match_valid, b_output_last_symbol, b_output_error;
   logic [16:0] b_output_match_position;
   logic [8:0]  b_output_match_length;
   logic [7:0]  b_output_match_next_symbol;

   lz77_min_match_filter #(.MIN_MATCH(5)) dut_b (
      .clk                      (clk),
      .rst_n                    (b_rst_n),
      .input_valid              (b_input_valid),
      .input_ready              (b_input_ready),
      .input_symbol             (b_input_symbol),
      .input_token_end          (b_input_token_end),
      .input_match_position     (b_input_match_position),
      .input_match_length       (b_input_match_length),
      .input_last_symbol        (b_input_last_symbol),
      .output_valid             (b_output_valid),
      .output_ready             (b_output_ready),
      .output_match_position    (b_output_match_position),
      .output_match_length      (b_output_match_length),
      .output_match_next_symbol (b_output_match_next_symbol),
      .output_match_valid       (b_output_match_valid),
      .output_last_symbol       (b_output_last_symbol),
      .output_error             (b_output_error)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; everything after this sees that edge's results.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_a(input logic [7:0] sym, input logic e, input logic [8:0] len,
                         input logic [16:0] pos, input logic last);
      a_input_valid          = 1'b1;
      a_input_symbol         = sym;
      a_input_token_end      = e;
      a_input_match_length   = len;
      a_input_match_position = pos;
      a_input_last_symbol    = last;
      chk("a.input_ready", a_input_ready, 1'b1);
      step();
      a_input_valid       = 1'b0;
      a_input_token_end   = 1'b0;
      a_input_last_symbol = 1'b0;
   endtask

   task automatic beat_b(input logic [7:0] sym, input logic e, input logic [8:0] len,
                         input logic [16:0] pos);
      b_input_valid          = 1'b1;
      b_input_symbol         = sym;
      b_input_token_end      = e;
      b_input_match_length   = len;
      b_input_match_position = pos;
      chk("b.input_ready", b_input_ready, 1'b1);
      step();
      b_input_valid     = 1'b0;
      b_input_token_end = 1'b0;
   endtask

   task automatic tok_a(input string tag, input logic [16:0] pos, input logic [8:0] len,
                        input logic [7:0] sym, input logic mv, input logic last);
      chk({tag, ".valid"}, a_output_valid, 1'b1);
      chk({tag, ".pos"},   a_output_match_position, pos);
      chk({tag, ".len"},   a_output_match_length, len);
      chk({tag, ".sym"},   a_output_match_next_symbol, sym);
      chk({tag, ".mv"},    a_output_match_valid, mv);
      chk({tag, ".last"},  a_output_last_symbol, last);
   endtask

   task automatic tok_b(input string tag, input logic [16:0] pos, input logic [8:0] len,
                        input logic [7:0] sym, input logic mv);
      chk({tag, ".valid"}, b_output_valid, 1'b1);
      chk({tag, ".pos"},   b_output_match_position, pos);
      chk({tag, ".len"},   b_output_match_length, len);
      chk({tag, ".sym"},   b_output_match_next_symbol, sym);
      chk({tag, ".mv"},    b_output_match_valid, mv);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] exp_lit [6];
      vectors     = 0;
      miscompares = 0;
      a_rst_n = 1'b0; a_input_valid = 1'b0; a_input_symbol = '0; a_input_token_end = 1'b0;
      a_input_match_position = '0; a_input_match_length = '0; a_input_last_symbol = 1'b0;
      a_output_ready = 1'b1;
      b_rst_n = 1'b0; b_input_valid = 1'b0; b_input_symbol = '0; b_input_token_end = 1'b0;
      b_input_match_position = '0; b_input_match_length = '0; b_input_last_symbol = 1'b0;
      b_output_ready = 1'b1;

      // Reset state
      step();
      step();
      chk("rst.valid", a_output_valid, 1'b0);
      chk("rst.ready", a_input_ready, 1'b0);
      chk("rst.error", a_output_error, 1'b0);
      chk("rst.pos",   a_output_match_position, 17'd0);
      chk("rst.sym",   a_output_match_next_symbol, 8'd0);
      chk("rst.last",  a_output_last_symbol, 1'b0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      step();
      chk("idle.ready", a_input_ready, 1'b1);

      // Short match L=2 after "a","b": literals a, b, c on consecutive cycles
      beat_a("a", 1'b0, 9'd0, 17'd0, 1'b0);
      chk("t1.nochange", a_output_valid, 1'b0);
      beat_a("b", 1'b0, 9'd0, 17'd0, 1'b0);
      chk("t1.nochange2", a_output_valid, 1'b0);
      beat_a("c", 1'b1, 9'd2, 17'd9, 1'b0);
      tok_a("t1.lit0", 17'd1, 9'd0, "a", 1'b0, 1'b0);
      chk("t1.ready0", a_input_ready, 1'b0);
      step();
      tok_a("t1.lit1", 17'd1, 9'd0, "b", 1'b0, 1'b0);
      chk("t1.ready1", a_input_ready, 1'b0);
      step();
      tok_a("t1.lit2", 17'd1, 9'd0, "c", 1'b0, 1'b0);
      chk("t1.ready2", a_input_ready, 1'b1);
      step();
      chk("t1.drained", a_output_valid, 1'b0);
      chk("t1.error", a_output_error, 1'b0);

      // Pass-through L=5 then back-to-back literal L=0
      for (int i = 0; i < 5; i++) begin
         beat_a(8'(8'h31 + i), 1'b0, 9'd0, 17'd0, 1'b0);
      end
      chk("t2.nochange", a_output_valid, 1'b0);
      beat_a("x", 1'b1, 9'd5, 17'd100, 1'b0);
      tok_a("t2.match", 17'd100, 9'd5, "x", 1'b1, 1'b0);
      beat_a("y", 1'b1, 9'd0, 17'd7, 1'b0);
      tok_a("t2.literal", 17'd7, 9'd0, "y", 1'b0, 1'b0);
      step();
      chk("t2.drained", a_output_valid, 1'b0);
      chk("t2.error", a_output_error, 1'b0);

      // Backpressure during L=2 expansion, output_ready 1,0,0,1
      beat_a("p", 1'b0, 9'd0, 17'd0, 1'b0);
      beat_a("q", 1'b0, 9'd0, 17'd0, 1'b0);
      beat_a("r", 1'b1, 9'd2, 17'd0, 1'b0);
      tok_a("t3.lit0", 17'd1, 9'd0, "p", 1'b0, 1'b0);
      chk("t3.ready0", a_input_ready, 1'b0);
      step();
      tok_a("t3.lit1", 17'd1, 9'd0, "q", 1'b0, 1'b0);
      a_output_ready = 1'b0;
      step();
      tok_a("t3.hold1", 17'd1, 9'd0, "q", 1'b0, 1'b0);
      chk("t3.ready1", a_input_ready, 1'b0);
      step();
      tok_a("t3.hold2", 17'd1, 9'd0, "q", 1'b0, 1'b0);
      chk("t3.ready2", a_input_ready, 1'b0);
      a_output_ready = 1'b1;
      step();
      tok_a("t3.lit2", 17'd1, 9'd0, "r", 1'b0, 1'b0);
      chk("t3.ready3", a_input_ready, 1'b1);
      step();
      chk("t3.drained", a_output_valid, 1'b0);

      // Length mismatch: L=2 after only 1 pending beat; ring holds q,s
      beat_a("s", 1'b0, 9'd0, 17'd0, 1'b0);
      beat_a("t", 1'b1, 9'd2, 17'd0, 1'b0);
      chk("t4.error", a_output_error, 1'b1);
      tok_a("t4.lit0", 17'd1, 9'd0, "q", 1'b0, 1'b0);
      step();
      tok_a("t4.lit1", 17'd1, 9'd0, "s", 1'b0, 1'b0);
      step();
      tok_a("t4.lit2", 17'd1, 9'd0, "t", 1'b0, 1'b0);
      step();

      // last_symbol on an expanded group: only the final literal carries it
      beat_a("u", 1'b0, 9'd0, 17'd0, 1'b0);
      beat_a("v", 1'b0, 9'd0, 17'd0, 1'b0);
      beat_a("w", 1'b1, 9'd2, 17'd0, 1'b1);
      tok_a("t5.lit0", 17'd1, 9'd0, "u", 1'b0, 1'b0);
      step();
      tok_a("t5.lit1", 17'd1, 9'd0, "v", 1'b0, 1'b0);
      step();
      tok_a("t5.lit2", 17'd1, 9'd0, "w", 1'b0, 1'b1);
      step();
      chk("t5.error_sticky", a_output_error, 1'b1);

      // Reset mid-expansion
      beat_a("g", 1'b0, 9'd0, 17'd0, 1'b0);
      beat_a("h", 1'b0, 9'd0, 17'd0, 1'b0);
      beat_a("i", 1'b1, 9'd2, 17'd0, 1'b0);
      tok_a("t6.lit0", 17'd1, 9'd0, "g", 1'b0, 1'b0);
      a_rst_n = 1'b0;
      step();
      chk("t6.valid", a_output_valid, 1'b0);
      chk("t6.sym",   a_output_match_next_symbol, 8'd0);
      chk("t6.error", a_output_error, 1'b0);
      chk("t6.ready", a_input_ready, 1'b0);
      a_rst_n = 1'b1;
      step();
      chk("t6.idle", a_output_valid, 1'b0);
      beat_a("z", 1'b1, 9'd0, 17'd3, 1'b0);
      tok_a("t6.fresh", 17'd3, 9'd0, "z", 1'b0, 1'b0);
      chk("t6.no_error", a_output_error, 1'b0);
      step();

      // last_symbol on a non-end beat is a protocol error
      beat_a("k", 1'b0, 9'd0, 17'd0, 1'b1);
      chk("t7.nochange", a_output_valid, 1'b0);
      chk("t7.error", a_output_error, 1'b1);

      // MIN_MATCH=5: L=2 group, then L=4 group whose symbols wrap the ring
      beat_b(8'h10, 1'b0, 9'd0, 17'd0);
      beat_b(8'h11, 1'b0, 9'd0, 17'd0);
      beat_b(8'h20, 1'b1, 9'd2, 17'd0);
      exp_lit[0] = 8'h10; exp_lit[1] = 8'h11; exp_lit[2] = 8'h20;
      for (int k = 0; k < 3; k++) begin
         tok_b($sformatf("b1.lit%0d", k), 17'd1, 9'd0, exp_lit[k], 1'b0);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         beat_b(8'(8'h30 + i), 1'b0, 9'd0, 17'd0);
      end
      beat_b(8'h40, 1'b1, 9'd4, 17'd0);
      exp_lit[0] = 8'h30; exp_lit[1] = 8'h31; exp_lit[2] = 8'h32;
      exp_lit[3] = 8'h33; exp_lit[4] = 8'h40;
      for (int k = 0; k < 5; k++) begin
         tok_b($sformatf("b2.lit%0d", k), 17'd1, 9'd0, exp_lit[k], 1'b0);
         step();
      end
      for (int i = 0; i < 5; i++) begin
         beat_b(8'(8'h60 + i), 1'b0, 9'd0, 17'd0);
      end
      beat_b(8'h50, 1'b1, 9'd5, 17'd200);
      tok_b("b3.match", 17'd200, 9'd5, 8'h50, 1'b1);
      step();
      chk("b3.drained", b_output_valid, 1'b0);
      chk("b3.error", b_output_error, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
